// File: rtl/aud_pkg.sv
// Shared types and constants for the I2S slot scheduler: FSM encoding,
// audio field position inside the AES-style subframe, and slot IDs.
package aud_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_STOP
  } sched_st_t;

  localparam int AUD_LSB = 4;
  localparam int AUD_MSB = 27;
  localparam int AUD_W   = AUD_MSB - AUD_LSB + 1;

  localparam logic SLOT_L = 1'b0;
  localparam logic SLOT_R = 1'b1;

endpackage

// File: rtl/aud_sample_fifo.sv
// Single-clock sample FIFO: registered write, combinational head read,
// wrap-bit pointers, synchronous flush.
module aud_sample_fifo
  import aud_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      push,
  input  logic [AUD_W-1:0]          wdata,
  input  logic                      pop,
  output logic [AUD_W-1:0]          head,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AUD_W-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone decide which
  // entries are valid, so resetting the array would only cost a reset tree.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/i2s_slot_scheduler.sv
// Routes tagged audio words into per-channel FIFOs and presents them to the
// I2S serializer in strict L/R order, substituting silence on underflow.
module i2s_slot_scheduler
  import aud_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 8
) (
  input  logic        s_axis_aud_aclk,
  input  logic        s_axis_aud_aresetn,
  input  logic        ctrl_en,
  input  logic        cnt_clr,
  input  logic [31:0] s_axis_aud_tdata,
  input  logic [2:0]  s_axis_aud_tid,
  input  logic        s_axis_aud_tvalid,
  output logic        s_axis_aud_tready,
  output logic [23:0] m_aud_tdata,
  output logic        m_aud_tch,
  output logic        m_aud_tvalid,
  input  logic        m_aud_tready,
  output logic        running,
  output logic        underflow,
  output logic        drop,
  output logic [15:0] underflow_cnt
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] HALF    = LW'(DEPTH / 2);
  localparam logic [LW-1:0] HALF_M1 = LW'(DEPTH / 2 - 1);

  sched_st_t          state, state_d;
  logic               tch;
  logic [NUM_CH-1:0]  push, pop, full, empty;
  logic [AUD_W-1:0]   head  [NUM_CH];
  logic [LW-1:0]      level [NUM_CH];
  logic               tid_ok, in_sel, out_active, hs, accept, flush, fill_ok;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    aud_sample_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (s_axis_aud_aclk),
      .rst_n (s_axis_aud_aresetn),
      .flush (flush),
      .push  (push[c]),
      .wdata (s_axis_aud_tdata[AUD_MSB:AUD_LSB]),
      .pop   (pop[c]),
      .head  (head[c]),
      .full  (full[c]),
      .empty (empty[c]),
      .level (level[c])
    );
  end

  // NOTE: every always_comb output gets a default first, so no path through
  // the block can leave a signal unassigned and infer a latch.
  always_comb begin
    tid_ok     = s_axis_aud_tid < 3'(NUM_CH);
    in_sel     = s_axis_aud_tid[0];
    out_active = (state == S_RUN) || (state == S_STOP);
    hs         = out_active && m_aud_tready;
    pop        = '0;
    pop[tch]   = hs && !empty[tch];

    // A pop on the addressed channel frees a slot in the same cycle.
    s_axis_aud_tready = (state != S_IDLE) &&
                        (!tid_ok || !full[in_sel] || pop[in_sel]);
    accept       = s_axis_aud_tvalid && s_axis_aud_tready;
    push         = '0;
    push[in_sel] = accept && tid_ok;

    fill_ok = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      fill_ok &= (level[c] >= HALF) || (push[c] && level[c] == HALF_M1);
    end

    state_d = state;
    unique case (state)
      S_IDLE: if (ctrl_en) state_d = S_FILL;
      S_FILL: begin
        if (!ctrl_en)     state_d = S_IDLE;
        else if (fill_ok) state_d = S_RUN;
      end
      S_RUN:  if (!ctrl_en) state_d = S_STOP;
      S_STOP: if (hs && tch == SLOT_R) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    flush = (state_d == S_IDLE);
  end

  always_ff @(posedge s_axis_aud_aclk) begin
    if (!s_axis_aud_aresetn) state <= S_IDLE;
    else                     state <= state_d;
  end

  always_ff @(posedge s_axis_aud_aclk) begin
    if (!s_axis_aud_aresetn) begin
      tch           <= SLOT_L;
      underflow     <= 1'b0;
      drop          <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      // Outside RUN/STOP the slot is parked on L, so each run opens on L.
      if (state_d != S_RUN && state_d != S_STOP) tch <= SLOT_L;
      else if (hs)                               tch <= ~tch;
      underflow <= hs && empty[tch];
      drop      <= accept && !tid_ok;
      if (cnt_clr)                                     underflow_cnt <= '0;
      else if (hs && empty[tch] && underflow_cnt != '1) underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

  assign m_aud_tvalid = out_active;
  assign m_aud_tch    = tch;
  assign m_aud_tdata  = (out_active && !empty[tch]) ? head[tch] : '0;
  assign running      = (state == S_RUN);

endmodule

// File: tb/tb_i2s_slot_scheduler.sv
// Self-checking bench: directed scenarios plus a random phase, every cycle
// compared against a queue-based model of the scheduler behaviour.
module tb_i2s_slot_scheduler;

  localparam int DEPTH  = 8;
  localparam int HALF   = DEPTH / 2;
  localparam int M_IDLE = 0;
  localparam int M_FILL = 1;
  localparam int M_RUN  = 2;
  localparam int M_STOP = 3;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        ctrl_en  = 1'b0;
  logic        cnt_clr  = 1'b0;
  logic [31:0] tdata    = '0;
  logic [2:0]  tid      = '0;
  logic        tvalid   = 1'b0;
  logic        tready;
  logic [23:0] m_tdata;
  logic        m_tch;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        running;
  logic        underflow;
  logic        drop;
  logic [15:0] ucnt;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int          st     = M_IDLE;
  bit          tch    = 1'b0;
  int          cnt    = 0;
  bit          uf_r   = 1'b0;
  bit          drop_r = 1'b0;
  logic [23:0] q0 [$];
  logic [23:0] q1 [$];

  always #5 clk = ~clk;

  i2s_slot_scheduler #(.NUM_CH(2), .DEPTH(DEPTH)) dut (
    .s_axis_aud_aclk    (clk),
    .s_axis_aud_aresetn (rst_n),
    .ctrl_en            (ctrl_en),
    .cnt_clr            (cnt_clr),
    .s_axis_aud_tdata   (tdata),
    .s_axis_aud_tid     (tid),
    .s_axis_aud_tvalid  (tvalid),
    .s_axis_aud_tready  (tready),
    .m_aud_tdata        (m_tdata),
    .m_aud_tch          (m_tch),
    .m_aud_tvalid       (m_tvalid),
    .m_aud_tready       (m_tready),
    .running            (running),
    .underflow          (underflow),
    .drop               (drop),
    .underflow_cnt      (ucnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input bit c);
    return c ? q1.size() : q0.size();
  endfunction

  function automatic logic [23:0] qhead(input bit c);
    return c ? q1[0] : q0[0];
  endfunction

  task automatic model_reset();
    st = M_IDLE; tch = 1'b0; cnt = 0; uf_r = 1'b0; drop_r = 1'b0;
    q0.delete(); q1.delete();
  endtask

  // One clock: compare outputs mid-cycle, advance the model, cross the edge.
  task automatic cycle();
    bit act, hs, dry, rdy, acc, pop0, pop1, stop_done;
    logic [23:0] exp_data;
    #1;
    act      = (st == M_RUN) || (st == M_STOP);
    hs       = act && m_tready;
    dry      = (qsize(tch) == 0);
    exp_data = (act && !dry) ? qhead(tch) : 24'd0;
    pop0     = hs && !tch && !dry;
    pop1     = hs &&  tch && !dry;
    if (st == M_IDLE)  rdy = 1'b0;
    else if (tid >= 2) rdy = 1'b1;
    else rdy = (qsize(tid[0]) < DEPTH) || (tid[0] ? pop1 : pop0);

    check("tready",    tready,    rdy);
    check("m_tvalid",  m_tvalid,  act);
    check("m_tch",     m_tch,     tch);
    check("m_tdata",   m_tdata,   exp_data);
    check("running",   running,   st == M_RUN);
    check("underflow", underflow, uf_r);
    check("drop",      drop,      drop_r);
    check("ucnt",      ucnt,      cnt);

    if (!rst_n) begin
      model_reset();
    end else begin
      acc    = tvalid && rdy;
      uf_r   = hs && dry;
      drop_r = acc && (tid >= 2);
      if (pop0) void'(q0.pop_front());
      if (pop1) void'(q1.pop_front());
      if (acc && tid == 0) q0.push_back(tdata[27:4]);
      if (acc && tid == 1) q1.push_back(tdata[27:4]);
      if (cnt_clr)                 cnt = 0;
      else if (uf_r && cnt < 65535) cnt = cnt + 1;
      stop_done = hs && tch;
      if (hs) tch = !tch;
      case (st)
        M_IDLE: if (ctrl_en) st = M_FILL;
        M_FILL: begin
          if (!ctrl_en) st = M_IDLE;
          else if (q0.size() >= HALF && q1.size() >= HALF) st = M_RUN;
        end
        M_RUN:  if (!ctrl_en) st = M_STOP;
        M_STOP: if (stop_done) st = M_IDLE;
        default: st = M_IDLE;
      endcase
      if (st == M_IDLE) begin
        q0.delete(); q1.delete(); tch = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Audio lands in [27:4]; the other bits carry random junk.
  task automatic push_word(input int ch, input int audio);
    logic [31:0] r;
    r      = $urandom();
    tvalid = 1'b1;
    tid    = 3'(ch);
    tdata  = {r[31:28], 24'(audio), r[3:0]};
    cycle();
    tvalid = 1'b0;
  endtask

  task automatic fill_4_4(input int base);
    for (int k = 0; k < 4; k++) push_word(0, base + k);
    for (int k = 0; k < 4; k++) push_word(1, base + 4 + k);
  endtask

  initial begin
    logic [31:0] r;
    @(posedge clk);
    #1;
    model_reset();
    idle(2);
    rst_n = 1'b1;
    cycle();

    // Fill and start: L 1..4, R 5..8, then two extra L words.
    ctrl_en = 1'b1;
    cycle();
    fill_4_4(1);
    push_word(0, 9);
    push_word(0, 10);

    // Drain: L1 R5 L2 R6 L3 R7 L4 R8 L9 R(underflow) L10.
    m_tready = 1'b1;
    idle(11);
    m_tready = 1'b0;
    idle(2);

    // Drop on an out-of-range channel ID.
    push_word(5, 24'hABCDEF);
    idle(2);

    // Backpressure: overfill FIFO[0], then R still accepted.
    for (int k = 0; k < 10; k++) push_word(0, 'h100 + k);
    push_word(1, 'h200);
    m_tready = 1'b1;
    cycle();
    // Pop and push on full FIFO[0] in the same cycle.
    push_word(0, 'h300);
    m_tready = 1'b0;
    idle(2);

    // Stop mid-frame: R, then L handshake, then disable.
    m_tready = 1'b1;
    idle(2);
    ctrl_en  = 1'b0;
    m_tready = 1'b0;
    idle(2);
    m_tready = 1'b1;
    cycle();
    m_tready = 1'b0;
    tvalid   = 1'b1;
    tid      = 3'd0;
    idle(2);
    tvalid   = 1'b0;

    // Counter saturation, then clear coinciding with an underflow.
    ctrl_en = 1'b1;
    cycle();
    fill_4_4('h400);
    m_tready = 1'b1;
    idle(65560);
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    idle(3);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) ctrl_en = !ctrl_en;
      tvalid   = 1'($urandom_range(0, 1));
      tid      = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
      r        = $urandom();
      tdata    = r;
      m_tready = ($urandom_range(0, 2) != 0);
      cnt_clr  = ($urandom_range(0, 199) == 0);
      cycle();
    end
    tvalid  = 1'b0;
    cnt_clr = 1'b0;

    // Reset mid-frame.
    ctrl_en  = 1'b0;
    m_tready = 1'b1;
    idle(4);
    m_tready = 1'b0;
    ctrl_en  = 1'b1;
    cycle();
    fill_4_4('h500);
    m_tready = 1'b1;
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    m_tready = 1'b0;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tready", tready, 0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
